// File: rtl/multi_ch_capture_buf.sv
// multi_ch_capture_buf: NCH-channel decimating capture RAM with a 1-cycle host read port.
// Optional CAPBUF_TIMESTAMP_EN adds a free-running cycle counter latched into trig_ts on trigger.
module multi_ch_capture_buf #(
    parameter int DATA_W  = 16,
    parameter int NCH     = 4,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int DECIM_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    trigger,
    input  logic [DECIM_W-1:0]      decim,
    input  logic [NCH*DATA_W-1:0]   din,
    input  logic                    rd_en,
    input  logic [2:0]              rd_ch,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
`ifdef CAPBUF_TIMESTAMP_EN
    output logic [ADDR_W:0]         wr_count,
    output logic [31:0]             trig_ts
`else
    output logic [ADDR_W:0]         wr_count
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0]  mem [NCH][DEPTH];
    logic [DECIM_W-1:0] decim_q, dcnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  rd_word;
    logic               arm_acc, trig_acc, we, last, rd_ok;

    assign busy     = state == ARMED || state == CAPTURE;
    assign done     = state == DONE;
    assign arm_acc  = (state == IDLE || state == DONE) && arm;
    assign trig_acc = state == ARMED && trigger && !abort;
    // reset gates the write so a capture interrupted by reset leaves the RAM untouched
    assign we       = state == CAPTURE && !abort && !reset && dcnt == decim_q;
    assign last     = we && wr_addr == ADDR_W'(DEPTH - 1);
    assign rd_ok    = done && {1'b0, rd_ch} < 4'(NCH) && {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NCH; c++)
            if (rd_ch == 3'(c)) rd_word = mem[c][rd_addr[AW-1:0]];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = arm ? ARMED : state;
            ARMED:      state_n = abort ? IDLE : trigger ? CAPTURE : ARMED;
            CAPTURE:    state_n = abort ? IDLE : last ? DONE : CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int c = 0; c < NCH; c++)
                mem[c][wr_addr[AW-1:0]] <= din[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            decim_q  <= '0;
            dcnt     <= '0;
            wr_addr  <= '0;
            wr_count <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_ok ? rd_word : '0;
            if (arm_acc) begin
                decim_q  <= decim;
                wr_count <= '0;
            end
            if (trig_acc) begin
                dcnt    <= decim_q;
                wr_addr <= '0;
            end
            if (state == CAPTURE && !abort) begin
                dcnt <= we ? '0 : dcnt + 1'b1;
                if (we) begin
                    wr_addr  <= wr_addr + 1'b1;
                    wr_count <= wr_count + 1'b1;
                end
            end
        end
    end

`ifdef CAPBUF_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (trig_acc) trig_ts <= ts_cnt;
        end
    end
`endif
endmodule
